alu_reg_sequencer: RTL
======================

ALU_REG_SEQUENCER -- requirements
Module: alu_reg_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, datapath width.
REQ-002 Parameter NREGS, default 8, register-file depth (power of two); AW = log2(NREGS).
REQ-003 clk  input  1  single clock, rising-edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 instr_valid / instr_ready  input / output  1 / 1  instruction handshake.
REQ-006 instr_op, instr_rd, instr_rs1, instr_rs2  input  4, AW, AW, AW  opcode, destination, sources.
REQ-007 load_en, load_addr, load_data  input  1, AW, WIDTH  register preload port.
REQ-008 alu_a, alu_b, alu_opcode  output  WIDTH, WIDTH, 4  operands/opcode to the combinational ALU.
REQ-009 alu_result, alu_zero, alu_negative, alu_carryout, alu_overflow  input  WIDTH, 1, 1, 1, 1  ALU outputs.
REQ-010 wb_valid, wb_rd, wb_data  output  1, AW, WIDTH  writeback strobe and payload.
REQ-011 flags  output  4  registered {zero, negative, carryout, overflow} of last completed instruction.
REQ-012 sticky  output  3  {overflow_seen, div0_seen, illegal_seen}; clr_sticky input 1 clears.
REQ-013 dbg_addr input AW, dbg_data output WIDTH: combinational register-file read.

Function
REQ-014 FSM states IDLE, EXEC, WB; instr_ready = 1 only in IDLE.
REQ-015 IDLE: instr_valid & instr_ready at edge -> capture op/rd/rs1/rs2, go EXEC.
REQ-016 EXEC: alu_a = reg[rs1], alu_b = reg[rs2], alu_opcode = op; at edge capture alu_result and four flags, go WB.
REQ-017 Outside EXEC, alu_a, alu_b, alu_opcode SHALL be 0.
REQ-018 WB: wb_valid = 1 for exactly one cycle with wb_rd = rd, wb_data = captured result; at edge write reg[rd], update flags, go IDLE.
REQ-019 Latency: accept at edge t, wb_valid high in cycle after edge t+1, register written at edge t+2; throughput one instruction per 3 cycles.
REQ-020 Register 0 reads as 0; writes to r0 discarded, wb_valid still pulses with wb_data = result.
REQ-021 Opcodes 4'b1110/4'b1111 illegal: EXEC -> IDLE directly, no wb_valid, no register/flags update, illegal_seen set.
REQ-022 DIV (4'b1010) or MOD (4'b1011) with alu_b == 0: result forced to 0, div0_seen set, writeback proceeds.
REQ-023 overflow_seen set when captured alu_overflow = 1 at WB.
REQ-024 clr_sticky clears all sticky bits; a set event in the same cycle wins.
REQ-025 load_en honoured only in IDLE; ignored in EXEC/WB; load to r0 discarded.
REQ-026 Load and instruction accept in the same IDLE cycle: both take effect; EXEC reads the loaded value.
REQ-027 Source equal to previous destination reads the written value (write completes before next EXEC).

Reset
REQ-028 rst_n low: state IDLE, all registers, flags, sticky, captured result 0; wb_valid 0; instr_ready 1 after release.
REQ-029 Reset mid-operation aborts the instruction with no writeback.

Structure
REQ-030 Shared package alu_pkg: opcode enum (AND..SRA, 0000-1101), ILLEGAL opcode constants, FSM state enum, WIDTH default.
REQ-031 One sub-module alu_regfile (NREGS x WIDTH, one write port, three combinational read ports, r0 hardwired 0); the ALU itself is instantiated by the parent, not here.

Verification
REQ-032 Load r1=5, r2=4; SUB(0111) rd=3 -> wb_valid once, wb_data=1, flags zero=0, r3=1 via dbg.
REQ-033 Load r1=3, r2=10; SLT(1000) rd=0 -> wb_valid pulses, wb_data=1, dbg r0 stays 0.
REQ-034 Op 1110 -> no wb_valid, illegal_seen=1, instr_ready back in 2 cycles; clr_sticky -> 0.
REQ-035 r2=0, DIV(1010) rd=4 -> wb_data=0, div0_seen=1.
REQ-036 Back-to-back ADD r3=r1+r2 then ADD r4=r3+r1 -> second uses updated r3; instr_valid held high sees ready every 3rd cycle.
REQ-037 rst_n asserted in EXEC -> no wb_valid, all registers 0, flags 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU register sequencer: opcode map, illegal opcodes, FSM states.
package alu_pkg;

   localparam int unsigned DefaultWidth = 32;

   typedef enum logic [3:0] {
      OpAnd  = 4'b0000,
      OpOr   = 4'b0001,
      OpXor  = 4'b0010,
      OpNor  = 4'b0011,
      OpSll  = 4'b0100,
      OpSrl  = 4'b0101,
      OpAdd  = 4'b0110,
      OpSub  = 4'b0111,
      OpSlt  = 4'b1000,
      OpMul  = 4'b1001,
      OpDiv  = 4'b1010,
      OpMod  = 4'b1011,
      OpSltu = 4'b1100,
      OpSra  = 4'b1101
   } alu_op_e;

   localparam logic [3:0] OpIllegal0 = 4'b1110;
   localparam logic [3:0] OpIllegal1 = 4'b1111;

   typedef enum logic [1:0] {
      StIdle,
      StExec,
      StWb
   } seq_state_e;

   function automatic logic is_illegal(input logic [3:0] op);
      return (op == OpIllegal0) || (op == OpIllegal1);
   endfunction

   function automatic logic is_divmod(input logic [3:0] op);
      return (op == OpDiv) || (op == OpMod);
   endfunction

endpackage

// File: rtl/alu_regfile.sv
// NREGS x WIDTH register file: one write port, three combinational read ports, r0 reads as zero.
module alu_regfile #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned NREGS = 8,
   parameter int unsigned AW    = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr_a,
   output logic [WIDTH-1:0] rdata_a,
   input  logic [AW-1:0]    raddr_b,
   output logic [WIDTH-1:0] rdata_b,
   input  logic [AW-1:0]    raddr_c,
   output logic [WIDTH-1:0] rdata_c
);

   logic [WIDTH-1:0] mem [NREGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NREGS); i++) begin
            mem[i] <= '0;
         end
      end else if (we && (waddr != '0)) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata_a = (raddr_a == '0) ? '0 : mem[raddr_a];
   assign rdata_b = (raddr_b == '0) ? '0 : mem[raddr_b];
   assign rdata_c = (raddr_c == '0) ? '0 : mem[raddr_c];

endmodule

// File: rtl/alu_reg_sequencer.sv
// Three-phase (accept, execute, writeback) sequencer driving an external combinational ALU
// and owning the register file, flags and sticky error bits.
module alu_reg_sequencer
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth,
   parameter int unsigned NREGS = 8,
   parameter int unsigned AW    = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic [3:0]       instr_op,
   input  logic [AW-1:0]    instr_rd,
   input  logic [AW-1:0]    instr_rs1,
   input  logic [AW-1:0]    instr_rs2,
   input  logic             load_en,
   input  logic [AW-1:0]    load_addr,
   input  logic [WIDTH-1:0] load_data,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_opcode,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_zero,
   input  logic             alu_negative,
   input  logic             alu_carryout,
   input  logic             alu_overflow,
   output logic             wb_valid,
   output logic [AW-1:0]    wb_rd,
   output logic [WIDTH-1:0] wb_data,
   output logic [3:0]       flags,
   output logic [2:0]       sticky,
   input  logic             clr_sticky,
   input  logic [AW-1:0]    dbg_addr,
   output logic [WIDTH-1:0] dbg_data
);

   seq_state_e       state_q, state_d;
   logic [3:0]       op_q;
   logic [AW-1:0]    rd_q, rs1_q, rs2_q;
   logic [WIDTH-1:0] result_q;
   logic [3:0]       cap_flags_q, flags_q;
   logic [2:0]       sticky_q, sticky_d;
   logic             rf_we;
   logic [AW-1:0]    rf_waddr;
   logic [WIDTH-1:0] rf_wdata, rs1_data, rs2_data;
   logic             accept, illegal, div0, capture;

   alu_regfile #(
      .WIDTH (WIDTH),
      .NREGS (NREGS),
      .AW    (AW)
   ) u_regfile (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (rf_we),
      .waddr   (rf_waddr),
      .wdata   (rf_wdata),
      .raddr_a (rs1_q),
      .rdata_a (rs1_data),
      .raddr_b (rs2_q),
      .rdata_b (rs2_data),
      .raddr_c (dbg_addr),
      .rdata_c (dbg_data)
   );

   assign accept  = (state_q == StIdle) && instr_valid;
   assign illegal = is_illegal(op_q);
   assign div0    = is_divmod(op_q) && (rs2_data == '0);
   assign capture = (state_q == StExec) && !illegal;

   // Loads and writebacks share the single write port; they never overlap in time.
   always_comb begin
      state_d     = state_q;
      instr_ready = 1'b0;
      alu_a       = '0;
      alu_b       = '0;
      alu_opcode  = '0;
      wb_valid    = 1'b0;
      wb_rd       = '0;
      wb_data     = '0;
      rf_we       = 1'b0;
      rf_waddr    = '0;
      rf_wdata    = '0;
      unique case (state_q)
         StIdle: begin
            instr_ready = 1'b1;
            if (load_en) begin
               rf_we    = 1'b1;
               rf_waddr = load_addr;
               rf_wdata = load_data;
            end
            if (instr_valid) state_d = StExec;
         end
         StExec: begin
            alu_a      = rs1_data;
            alu_b      = rs2_data;
            alu_opcode = op_q;
            state_d    = illegal ? StIdle : StWb;
         end
         StWb: begin
            wb_valid = 1'b1;
            wb_rd    = rd_q;
            wb_data  = result_q;
            rf_we    = 1'b1;
            rf_waddr = rd_q;
            rf_wdata = result_q;
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Clear first so a same-cycle set event wins.
   always_comb begin
      sticky_d = clr_sticky ? 3'b000 : sticky_q;
      if ((state_q == StExec) && illegal) sticky_d[0] = 1'b1;
      if (capture && div0)                sticky_d[1] = 1'b1;
      if ((state_q == StWb) && cap_flags_q[0]) sticky_d[2] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         op_q        <= '0;
         rd_q        <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         result_q    <= '0;
         cap_flags_q <= '0;
         flags_q     <= '0;
         sticky_q    <= '0;
      end else begin
         state_q  <= state_d;
         sticky_q <= sticky_d;
         if (accept) begin
            op_q  <= instr_op;
            rd_q  <= instr_rd;
            rs1_q <= instr_rs1;
            rs2_q <= instr_rs2;
         end
         if (capture) begin
            result_q    <= div0 ? '0 : alu_result;
            cap_flags_q <= {alu_zero, alu_negative, alu_carryout, alu_overflow};
         end
         if (state_q == StWb) flags_q <= cap_flags_q;
      end
   end

   assign flags  = flags_q;
   assign sticky = sticky_q;

endmodule
